imem_fetch: RTL and testbench

- Instruction fetch unit: the reader side of the instruction memory.
- Generates word addresses into imem (6-bit word address, 32-bit combinational read data) and buffers fetched words with their PCs in a small prefetch FIFO.
- Presents them to decode over a valid/ready handshake.
- Handles branch redirects by flushing the FIFO and restarting fetch at the target.

---
 rtl/imem_fetch.sv | 118 +++++++++++
 tb/tb_imem_fetch.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch.sv
// Instruction fetch unit: walks the program counter through imem, buffers
// fetched words with their PCs in a small prefetch FIFO, and hands them to
// decode over a valid/ready handshake. A redirect flushes the FIFO and
// restarts fetch at the branch target.
module imem_fetch #(
    parameter int unsigned         PC_W     = 64,
    parameter int unsigned         DEPTH    = 4,
    parameter logic [PC_W-1:0]     RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [5:0]                 imem_addr,
    input  logic [31:0]                imem_q,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [PC_W-1:0]            out_pc,
    input  logic                       redirect,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic [PC_W-1:0] mem_pc_q    [DEPTH];
    logic [PC_W-1:0] mem_pc_d    [DEPTH];
    logic [31:0]     mem_instr_q [DEPTH];
    logic [31:0]     mem_instr_d [DEPTH];

    logic pop;
    logic push;
    logic unused_redirect_lsbs;

    // The low two bits of a redirect target are forced to zero, so they are never read.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Handshake decode: a flush blocks the push, and a full FIFO only accepts a new word when the head leaves.
    always_comb begin
        pop  = out_valid & out_ready;
        push = ~redirect & ((count_q < CW'(DEPTH)) | pop);
    end

    // Next-state for the fetch PC, pointers and occupancy; redirect overrides everything.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + PC_W'(4);
                tail_d     = tail_q + AW'(1);
            end
            if (pop) begin
                head_d = head_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Next-state for the FIFO storage: the word read at fetch_pc lands at the tail on a push.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_pc_d[i]    = mem_pc_q[i];
            mem_instr_d[i] = mem_instr_q[i];
        end
        if (push) begin
            mem_pc_d[tail_q]    = fetch_pc_q;
            mem_instr_d[tail_q] = imem_q;
        end
    end

    // Control state register with asynchronous reset back to the reset PC and an empty FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Storage register; contents are meaningless while the entry is not occupied, so no reset.
    always_ff @(posedge clk) begin
        mem_pc_q    <= mem_pc_d;
        mem_instr_q <= mem_instr_d;
    end

    // Outputs come only from registered state; the head is masked to zero whenever the FIFO is empty.
    always_comb begin
        imem_addr = fetch_pc_q[7:2];
        out_valid = (count_q != '0);
        count     = count_q;
        out_instr = '0;
        out_pc    = '0;
        if (out_valid) begin
            out_instr = mem_instr_q[head_q];
            out_pc    = mem_pc_q[head_q];
        end
    end

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: imem is modelled as word i = A000_0000 | i,
// and each scenario task drives its stimulus and checks hand-computed values.
module tb_imem_fetch;

    logic        clk;
    logic        reset;
    logic [5:0]  imem_addr;
    logic [31:0] imem_q;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [2:0]  count;

    int vectors;
    int miscompares;

    imem_fetch #(
        .PC_W     (64),
        .DEPTH    (4),
        .RESET_PC (64'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_q      (imem_q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .count       (count)
    );

    // Combinational instruction memory model.
    assign imem_q = 32'hA000_0000 | {26'd0, imem_addr};

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Put the DUT back in reset and release it between edges.
    task automatic do_reset(input logic ready);
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = ready;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        step();
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_valid: got %b expected 0", out_valid);
        end
        vectors++;
        if (count !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_count: got %0d expected 0", count);
        end
        vectors++;
        if (imem_addr !== 6'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_addr: got %0d expected 0", imem_addr);
        end
        vectors++;
        if (out_instr !== 32'h0 || out_pc !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_head: got %h/%h expected 0/0", out_pc, out_instr);
        end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stream_pre_edge_valid: got %b expected 0", out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 64'(4 * i) ||
                out_instr !== (32'hA000_0000 | 32'(i))) begin
                miscompares++;
                $display("[TB] FAIL stream_%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         i, out_valid, out_pc, out_instr, 64'(4 * i), 32'hA000_0000 | 32'(i));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        for (int i = 1; i <= 8; i++) begin
            step();
            vectors++;
            if (count !== 3'((i < 4) ? i : 4) || out_pc !== 64'h0 || out_instr !== 32'hA000_0000) begin
                miscompares++;
                $display("[TB] FAIL hold_%0d: got cnt=%0d pc=%h instr=%h expected cnt=%0d pc=0 instr=a0000000",
                         i, count, out_pc, out_instr, (i < 4) ? i : 4);
            end
        end
        vectors++;
        if (imem_addr !== 6'd4) begin
            miscompares++;
            $display("[TB] FAIL hold_addr: got %0d expected 4", imem_addr);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || count !== 3'd4 || out_pc !== 64'(4 * i) ||
                out_instr !== (32'hA000_0000 | 32'(i))) begin
                miscompares++;
                $display("[TB] FAIL drain_%0d: got v=%b cnt=%0d pc=%h instr=%h expected v=1 cnt=4 pc=%h",
                         i, out_valid, count, out_pc, out_instr, 64'(4 * i));
            end
            step();
        end
    endtask

    task automatic test_full_single_pop();
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++;
        if (count !== 3'd4) begin
            miscompares++;
            $display("[TB] FAIL single_pop_count: got %0d expected 4", count);
        end
        vectors++;
        if (out_pc !== 64'h4 || out_instr !== 32'hA000_0001) begin
            miscompares++;
            $display("[TB] FAIL single_pop_head: got %h/%h expected 4/a0000001", out_pc, out_instr);
        end
        vectors++;
        if (imem_addr !== 6'd5) begin
            miscompares++;
            $display("[TB] FAIL single_pop_addr: got %0d expected 5", imem_addr);
        end
        step();
        vectors++;
        if (count !== 3'd4 || out_pc !== 64'h4 || imem_addr !== 6'd5) begin
            miscompares++;
            $display("[TB] FAIL single_pop_hold: got cnt=%0d pc=%h addr=%0d expected 4/4/5",
                     count, out_pc, imem_addr);
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if (count !== 3'd3) begin
            miscompares++;
            $display("[TB] FAIL redirect_pre_count: got %0d expected 3", count);
        end
        redirect    = 1'b1;
        redirect_pc = 64'h2B;
        step();
        redirect = 1'b0;
        vectors++;
        if (count !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 6'd10) begin
            miscompares++;
            $display("[TB] FAIL redirect_flush: got cnt=%0d v=%b addr=%0d expected 0/0/10",
                     count, out_valid, imem_addr);
        end
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 64'h28 || out_instr !== 32'hA000_000A) begin
            miscompares++;
            $display("[TB] FAIL redirect_target: got v=%b pc=%h instr=%h expected 1/28/a000000a",
                     out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_instr [3];
        exp_instr[0] = 32'hA000_0020;
        exp_instr[1] = 32'hA000_0021;
        exp_instr[2] = 32'hA000_0022;
        do_reset(1'b0);
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 64'h40;
        step();
        redirect_pc = 64'h80;
        step();
        redirect = 1'b0;
        vectors++;
        if (count !== 3'd0 || imem_addr !== 6'h20) begin
            miscompares++;
            $display("[TB] FAIL b2b_flush: got cnt=%0d addr=%0d expected 0/32", count, imem_addr);
        end
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if (count !== 3'd3 || out_pc !== 64'h80 || out_instr !== exp_instr[0]) begin
            miscompares++;
            $display("[TB] FAIL b2b_head: got cnt=%0d pc=%h instr=%h expected 3/80/%h",
                     count, out_pc, out_instr, exp_instr[0]);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] exp_pc    [4];
        logic [31:0] exp_instr [4];
        exp_pc[0] = 64'hF8;  exp_instr[0] = 32'hA000_003E;
        exp_pc[1] = 64'hFC;  exp_instr[1] = 32'hA000_003F;
        exp_pc[2] = 64'h100; exp_instr[2] = 32'hA000_0000;
        exp_pc[3] = 64'h104; exp_instr[3] = 32'hA000_0001;
        do_reset(1'b1);
        redirect    = 1'b1;
        redirect_pc = 64'hF8;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || out_instr !== exp_instr[i]) begin
                miscompares++;
                $display("[TB] FAIL wrap_%0d: got v=%b pc=%h instr=%h expected 1/%h/%h",
                         i, out_valid, out_pc, out_instr, exp_pc[i], exp_instr[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) step();
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || count !== 3'd0 || imem_addr !== 6'd0 || out_pc !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got v=%b cnt=%0d addr=%0d pc=%h expected 0/0/0/0",
                     out_valid, count, imem_addr, out_pc);
        end
        #1;
        reset = 1'b0;
        step();
        vectors++;
        if (out_valid !== 1'b1 || count !== 3'd1 || out_pc !== 64'h0 || out_instr !== 32'hA000_0000) begin
            miscompares++;
            $display("[TB] FAIL async_resume: got v=%b cnt=%0d pc=%h instr=%h expected 1/1/0/a0000000",
                     out_valid, count, out_pc, out_instr);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_full_single_pop();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
